// File: rtl/axis_frame_deframer.sv
// rtl/axis_frame_deframer.sv - ChaCha20 receive-side frame deframer (28-word header or 16-word data-only frames)
// Optional frame/error counters are built when DEFRAME_STATS_EN is defined.
module axis_frame_deframer (
   input  logic         deframe_clk,
   input  logic         deframe_reset,
   input  logic         s_axis_valid,
   input  logic [31:0]  s_axis_data,
   input  logic         s_axis_last,
   output logic         s_axis_ready,
   input  logic         hdr_en,
   input  logic         frame_ready,
   output logic         frame_valid,
   output logic         frame_err,
   output logic [255:0] frame_key,
   output logic [63:0]  frame_nonce,
   output logic [63:0]  frame_counter,
   output logic [511:0] frame_data
`ifdef DEFRAME_STATS_EN
   ,
   output logic [15:0]  frame_count,
   output logic [15:0]  err_count
`endif
);

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_DRAIN   = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;

   logic [1:0]   r_state;
   logic [4:0]   r_idx;
   logic         r_mode;
   logic         r_ready;
   logic         r_valid;
   logic         r_err;
   logic [255:0] r_key;
   logic [63:0]  r_nonce;
   logic [63:0]  r_counter;
   logic [511:0] r_data;

   logic         w_accept;
   logic         w_mode;
   logic [4:0]   w_last_idx;
   logic         w_release;
   logic         w_write;

   assign w_accept   = s_axis_valid & r_ready;
   // The first beat decides the frame format; later beats use the latched copy.
   assign w_mode     = (r_idx == 5'd0) ? hdr_en : r_mode;
   assign w_last_idx = w_mode ? 5'd27 : 5'd15;
   assign w_release  = (r_state == ST_HOLD) & frame_ready;
   assign w_write    = (r_state == ST_COLLECT) & w_accept;

   always_ff @(posedge deframe_clk or posedge deframe_reset) begin
      if (deframe_reset) begin
         r_state <= ST_COLLECT;
         r_idx   <= 5'd0;
         r_mode  <= 1'b0;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_idx <= r_idx + 5'd1;
                  if (r_idx == 5'd0)
                     r_mode <= hdr_en;
                  if (s_axis_last) begin
                     r_state <= ST_HOLD;
                     r_ready <= 1'b0;
                     r_valid <= 1'b1;
                     r_err   <= (r_idx != w_last_idx);
                  end else if (r_idx == w_last_idx) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               r_ready <= 1'b1;
               if (w_accept && s_axis_last) begin
                  r_state <= ST_HOLD;
                  r_ready <= 1'b0;
                  r_valid <= 1'b1;
                  r_err   <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (frame_ready) begin
                  r_state <= ST_COLLECT;
                  r_idx   <= 5'd0;
                  r_mode  <= 1'b0;
                  r_ready <= 1'b1;
                  r_valid <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_COLLECT;
               r_idx   <= 5'd0;
               r_ready <= 1'b0;
               r_valid <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   // Slots are cleared on release so an early-terminated frame reads zero past its last word.
   always_ff @(posedge deframe_clk or posedge deframe_reset) begin
      if (deframe_reset) begin
         r_key     <= '0;
         r_nonce   <= '0;
         r_counter <= '0;
         r_data    <= '0;
      end else if (w_release) begin
         r_key     <= '0;
         r_nonce   <= '0;
         r_counter <= '0;
         r_data    <= '0;
      end else if (w_write) begin
         for (int k = 0; k < 8; k++) begin
            if (w_mode && (r_idx == 5'(k)))
               r_key[255 - 32*k -: 32] <= s_axis_data;
         end
         for (int k = 0; k < 2; k++) begin
            if (w_mode && (r_idx == 5'(k + 8)))
               r_nonce[63 - 32*k -: 32] <= s_axis_data;
            if (w_mode && (r_idx == 5'(k + 10)))
               r_counter[63 - 32*k -: 32] <= s_axis_data;
         end
         for (int k = 0; k < 16; k++) begin
            if (r_idx == (w_mode ? 5'(k + 12) : 5'(k)))
               r_data[511 - 32*k -: 32] <= s_axis_data;
         end
      end
   end

`ifdef DEFRAME_STATS_EN
   logic [15:0] r_frame_count;
   logic [15:0] r_err_count;

   always_ff @(posedge deframe_clk or posedge deframe_reset) begin
      if (deframe_reset) begin
         r_frame_count <= 16'd0;
         r_err_count   <= 16'd0;
      end else if (w_release) begin
         if (r_err)
            r_err_count <= r_err_count + 16'd1;
         else
            r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign frame_count = r_frame_count;
   assign err_count   = r_err_count;
`endif

   assign s_axis_ready  = r_ready;
   assign frame_valid   = r_valid;
   assign frame_err     = r_err;
   assign frame_key     = r_key;
   assign frame_nonce   = r_nonce;
   assign frame_counter = r_counter;
   assign frame_data    = r_data;

endmodule

// File: tb/tb_axis_frame_deframer.sv
// tb/tb_axis_frame_deframer.sv - scoreboard bench for axis_frame_deframer with a slot-array reference model
module tb_axis_frame_deframer;

   logic         deframe_clk = 1'b0;
   logic         deframe_reset = 1'b1;
   logic         s_axis_valid = 1'b0;
   logic [31:0]  s_axis_data = '0;
   logic         s_axis_last = 1'b0;
   logic         s_axis_ready;
   logic         hdr_en = 1'b0;
   logic         frame_ready = 1'b0;
   logic         frame_valid;
   logic         frame_err;
   logic [255:0] frame_key;
   logic [63:0]  frame_nonce;
   logic [63:0]  frame_counter;
   logic [511:0] frame_data;
`ifdef DEFRAME_STATS_EN
   logic [15:0]  frame_count;
   logic [15:0]  err_count;
`endif

   axis_frame_deframer dut (
      .deframe_clk   (deframe_clk),
      .deframe_reset (deframe_reset),
      .s_axis_valid  (s_axis_valid),
      .s_axis_data   (s_axis_data),
      .s_axis_last   (s_axis_last),
      .s_axis_ready  (s_axis_ready),
      .hdr_en        (hdr_en),
      .frame_ready   (frame_ready),
      .frame_valid   (frame_valid),
      .frame_err     (frame_err),
      .frame_key     (frame_key),
      .frame_nonce   (frame_nonce),
      .frame_counter (frame_counter),
      .frame_data    (frame_data)
`ifdef DEFRAME_STATS_EN
      ,
      .frame_count   (frame_count),
      .err_count     (err_count)
`endif
   );

   always #5 deframe_clk = ~deframe_clk;

   typedef struct {
      logic [255:0] key;
      logic [63:0]  nonce;
      logic [63:0]  counter;
      logic [511:0] data;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   frames_ended = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: lay the accepted words into a 28-slot frame image, then slice fields out of it.
   function automatic exp_t model(input bit mode, input logic [31:0] w[$]);
      exp_t        e;
      logic [31:0] slot [28];
      int          n;
      n = mode ? 28 : 16;
      for (int i = 0; i < 28; i++) slot[i] = '0;
      for (int i = 0; i < w.size() && i < n; i++)
         slot[mode ? i : i + 12] = w[i];
      e.key = '0; e.nonce = '0; e.counter = '0; e.data = '0;
      for (int k = 0; k < 8; k++)  e.key[255 - 32*k -: 32] = slot[k];
      for (int k = 0; k < 2; k++)  e.nonce[63 - 32*k -: 32] = slot[8 + k];
      for (int k = 0; k < 2; k++)  e.counter[63 - 32*k -: 32] = slot[10 + k];
      for (int k = 0; k < 16; k++) e.data[511 - 32*k -: 32] = slot[12 + k];
      e.err = (w.size() != n);
      return e;
   endfunction

   task automatic drive_beat(input logic [31:0] d, input logic l, input logic he);
      bit acc;
      int n;
      n = 0;
      s_axis_valid = 1'b1;
      s_axis_data  = d;
      s_axis_last  = l;
      hdr_en       = he;
      forever begin
         acc = s_axis_ready;
         @(posedge deframe_clk); #1;
         if (acc) break;
         n++;
         if (n > 200) begin
            $display("FAIL beat_accept_timeout: got no accept expected accept within 200 cycles");
            $fatal(1, "timeout");
         end
      end
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
      hdr_en       = 1'($urandom_range(0, 1));
   endtask

   task automatic send_frame(input bit mode, input int len, input bit seq, input logic [31:0] base);
      logic [31:0] w[$];
      for (int i = 0; i < len; i++)
         w.push_back(seq ? base + 32'(i) : $urandom);
      exp_q.push_back(model(mode, w));
      for (int i = 0; i < len; i++) begin
         if (!seq && $urandom_range(0, 3) == 0) begin
            @(posedge deframe_clk); #1;
         end
         drive_beat(w[i], (i == len - 1), (i == 0) ? mode : 1'($urandom_range(0, 1)));
      end
      frames_ended++;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 || frame_valid) begin
         @(posedge deframe_clk); #1;
         n++;
         if (n > 500) begin
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            $fatal(1, "timeout");
         end
      end
      repeat (3) @(posedge deframe_clk);
      #1;
   endtask

   // Monitor: owns frame_ready and every comparison.
   initial begin
      bit          in_frame;
      bit          pend;
      int          hold;
      int          rst_seen;
      int          seen;
      logic [15:0] exp_fc;
      logic [15:0] exp_ec;
      exp_t        cur;
      in_frame = 0; pend = 0; hold = 0; rst_seen = 0; seen = 0;
      exp_fc = '0; exp_ec = '0;
      forever begin
         @(negedge deframe_clk);
         if (deframe_reset) begin
            chk("rst_ready", s_axis_ready, 0);
            chk("rst_valid", frame_valid, 0);
            chk("rst_err", frame_err, 0);
            chk("rst_key", frame_key, 0);
            chk("rst_nonce", frame_nonce, 0);
            chk("rst_counter", frame_counter, 0);
            chk("rst_data", frame_data, 0);
`ifdef DEFRAME_STATS_EN
            chk("rst_frame_count", frame_count, 0);
            chk("rst_err_count", err_count, 0);
`endif
            in_frame = 0; pend = 0; frame_ready = 1'b0;
            exp_fc = '0; exp_ec = '0;
            rst_seen = 2;
         end else begin
            if (rst_seen == 2) begin
               chk("ready_low_before_first_edge", s_axis_ready, 0);
               rst_seen = 1;
            end else begin
               rst_seen = 0;
               chk("ready_vs_valid", s_axis_ready, !frame_valid);
            end
            if (pend) begin
               chk("valid_after_handshake", frame_valid, 0);
`ifdef DEFRAME_STATS_EN
               chk("frame_count", frame_count, exp_fc);
               chk("err_count", err_count, exp_ec);
`endif
               pend = 0; in_frame = 0; frame_ready = 1'b0;
            end else if (frame_valid) begin
               if (!in_frame) begin
                  in_frame = 1;
                  seen++;
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_frame: got frame_valid expected none");
                     cur = '{key: '0, nonce: '0, counter: '0, data: '0, err: 1'b0};
                  end else begin
                     cur = exp_q.pop_front();
                  end
                  hold = (seen == 1) ? 5 : $urandom_range(0, 5);
               end
               chk("frame_err", frame_err, cur.err);
               chk("frame_key", frame_key, cur.key);
               chk("frame_nonce", frame_nonce, cur.nonce);
               chk("frame_counter", frame_counter, cur.counter);
               chk("frame_data", frame_data, cur.data);
               if (hold == 0) begin
                  frame_ready = 1'b1;
                  pend = 1;
                  if (cur.err) exp_ec = exp_ec + 16'd1;
                  else         exp_fc = exp_fc + 16'd1;
               end else begin
                  hold--;
                  frame_ready = 1'b0;
               end
            end else begin
               frame_ready = 1'($urandom_range(0, 1));
            end
            if (frames_ended != seen) begin
               checks++; errors++;
               $display("FAIL valid_latency: got %0d frames presented expected %0d", seen, frames_ended);
               seen = frames_ended;
            end
         end
      end
   end

   // Stimulus
   initial begin
      int n;
      int r;
      bit m;
      repeat (3) @(posedge deframe_clk);
      #1 deframe_reset = 1'b0;
      @(posedge deframe_clk); #1;

      send_frame(1'b1, 28, 1'b1, 32'h0000_0000);
      send_frame(1'b0, 16, 1'b1, 32'hA000_0000);
      send_frame(1'b1, 11, 1'b1, 32'h0000_0000);
      send_frame(1'b1, 30, 1'b1, 32'h0000_0000);
      send_frame(1'b0, 1, 1'b1, 32'h1234_0000);
      send_frame(1'b0, 17, 1'b1, 32'h5500_0000);

      for (int f = 0; f < 40; f++) begin
         m = 1'($urandom_range(0, 1));
         n = m ? 28 : 16;
         r = $urandom_range(0, 3);
         if (r == 2)      n = $urandom_range(1, n - 1);
         else if (r == 3) n = n + $urandom_range(1, 4);
         send_frame(m, n, 1'b0, 32'h0);
      end
      wait_idle();

      for (int i = 0; i < 5; i++)
         drive_beat(32'hDEAD_0000 + 32'(i), 1'b0, 1'b1);
      deframe_reset = 1'b1;
      repeat (2) @(posedge deframe_clk);
      #1 deframe_reset = 1'b0;
      @(posedge deframe_clk); #1;
      send_frame(1'b1, 28, 1'b1, 32'h0000_0100);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
